// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce_bank slice:
//   - default parameter constants for the bank and its channels
//   - clog2_min1(): counter width helper that never returns less than 1
//   - chan_status_t: bundle of the registered per-channel outputs
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_MAX_COUNT   = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Width needed to hold 0..n-1, never below 1 so a MAX_COUNT of 1 still
  // yields a legal (constant-zero) counter vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Registered outputs of one debounced channel.
  typedef struct packed {
    logic out;
    logic edj;
    logic rise;
    logic fall;
    logic rise_flag;
    logic fall_flag;
  } chan_status_t;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One bit of the debouncer: input synchroniser, hysteresis counter, debounced
// level, single-cycle edge pulses and sticky rise/fall flags.
//
// Ports:
//   clock     in   system clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   in_i      in   raw, possibly asynchronous input bit
//   clear_i   in   synchronous clear of the sticky flags
//   status_o  out  registered out / edj / rise / fall / rise_flag / fall_flag
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_i,
  input  logic         clear_i,
  output chan_status_t status_o
);

  localparam int COUNTER_BITS = clog2_min1(MAX_COUNT);
  localparam logic [COUNTER_BITS-1:0] LAST_COUNT = COUNTER_BITS'(MAX_COUNT - 1);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic                    out_q, out_d;
  logic                    edj_q, edj_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    rise_flag_q, rise_flag_d;
  logic                    fall_flag_q, fall_flag_d;
  logic                    sync_s;

  // Synchronised level is the last stage of the chain.
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift: plain flop-to-flop, nothing between stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Hysteresis counter and debounced level; pulses default to zero.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    edj_d  = 1'b0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_s != out_q) begin
      if (cnt_q == LAST_COUNT) begin
        // New level has been seen for MAX_COUNT consecutive cycles.
        out_d  = sync_s;
        edj_d  = 1'b1;
        rise_d = sync_s & ~out_q;
        fall_d = ~sync_s & out_q;
        cnt_d  = {COUNTER_BITS{1'b0}};
      end else begin
        cnt_d = cnt_q + COUNTER_BITS'(1);
      end
    end else begin
      // Any return to the current level restarts the count.
      cnt_d = {COUNTER_BITS{1'b0}};
    end
  end

  // Sticky flags: a set in the same cycle as clear takes priority.
  always_comb begin
    rise_flag_d = (rise_flag_q & ~clear_i) | rise_d;
    fall_flag_d = (fall_flag_q & ~clear_i) | fall_d;
  end

  // State register for the whole channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q       <= {COUNTER_BITS{1'b0}};
      out_q       <= RESET_VALUE;
      edj_q       <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      rise_flag_q <= 1'b0;
      fall_flag_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      edj_q       <= edj_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rise_flag_q <= rise_flag_d;
      fall_flag_q <= fall_flag_d;
    end
  end

  // Pack registered outputs.
  always_comb begin
    status_o.out       = out_q;
    status_o.edj       = edj_q;
    status_o.rise      = rise_q;
    status_o.fall      = fall_q;
    status_o.rise_flag = rise_flag_q;
    status_o.fall_flag = fall_flag_q;
  end

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Multi-channel debouncer for raw pad inputs (buttons, switches, DIP banks).
// Each channel is an independent debounce_channel; any_edge summarises the
// registered edge pulses of all channels.
//
// Ports:
//   clock      in   system clock, all state on posedge
//   reset_n    in   asynchronous active-low reset
//   in         in   [CHANNELS] raw, possibly asynchronous inputs
//   clear      in   [CHANNELS] synchronous clear of the sticky flags
//   out        out  [CHANNELS] debounced level
//   edj        out  [CHANNELS] 1-cycle pulse on either edge of out
//   rise       out  [CHANNELS] 1-cycle pulse on rising edge of out
//   fall       out  [CHANNELS] 1-cycle pulse on falling edge of out
//   rise_flag  out  [CHANNELS] sticky: rise seen since last clear
//   fall_flag  out  [CHANNELS] sticky: fall seen since last clear
//   any_edge   out  OR of edj (combinational from registers)
// -----------------------------------------------------------------------------
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CHANNELS    = DEFAULT_CHANNELS,
  parameter int   MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] edj,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rise_flag,
  output logic [CHANNELS-1:0] fall_flag,
  output logic                any_edge
);

  chan_status_t status_s [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .MAX_COUNT   (MAX_COUNT),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VALUE (RESET_VALUE)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_i     (in[g]),
      .clear_i  (clear[g]),
      .status_o (status_s[g])
    );

    assign out[g]       = status_s[g].out;
    assign edj[g]       = status_s[g].edj;
    assign rise[g]      = status_s[g].rise;
    assign fall[g]      = status_s[g].fall;
    assign rise_flag[g] = status_s[g].rise_flag;
    assign fall_flag[g] = status_s[g].fall_flag;
  end

  // Only a function of edj registers, so it is glitch-free within a cycle.
  assign any_edge = |edj;

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int   CH = 4;
  localparam int   MC = 16;
  localparam int   SS = 2;
  localparam int   HL = SS + MC;
  localparam logic RV = 1'b0;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH-1:0] in_s, clear_s, out_s, edj_s, rise_s, fall_s, rflag_s, fflag_s;
  logic          any_s;
  logic [0:0]    in1_s, clear1_s, out1_s, edj1_s, rise1_s, fall1_s, rflag1_s, fflag1_s;
  logic          any1_s;

  always #5 clock = ~clock;

  debounce_bank #(.CHANNELS(CH), .MAX_COUNT(MC), .SYNC_STAGES(SS), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset_n(reset_n), .in(in_s), .clear(clear_s),
    .out(out_s), .edj(edj_s), .rise(rise_s), .fall(fall_s),
    .rise_flag(rflag_s), .fall_flag(fflag_s), .any_edge(any_s)
  );

  debounce_bank #(.CHANNELS(1), .MAX_COUNT(1), .SYNC_STAGES(SS), .RESET_VALUE(RV)) dut1 (
    .clock(clock), .reset_n(reset_n), .in(in1_s), .clear(clear1_s),
    .out(out1_s), .edj(edj1_s), .rise(rise1_s), .fall(fall1_s),
    .rise_flag(rflag1_s), .fall_flag(fflag1_s), .any_edge(any1_s)
  );

  int checks = 0;
  int errors = 0;
  int tcount = 0;

  // Reference model: per-channel history of input samples taken at each edge
  // (bit 0 = newest). A channel accepts the opposite level once the MAX_COUNT
  // samples that have cleared the synchroniser all disagree with its level.
  logic [HL-1:0] hist_m [CH];
  logic [CH-1:0] out_m, edj_m, rise_m, fall_m, rflag_m, fflag_m;
  logic [SS:0]   hist1_m;
  logic          out1_m, edj1_m, rise1_m, fall1_m, rflag1_m, fflag1_m;

  function automatic logic window_flips(input logic [HL-1:0] h, input int lo, input int n,
                                        input logic cur);
    logic r;
    r = 1'b1;
    for (int k = lo; k < lo + n; k++) begin
      if (h[k] === cur) r = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) hist_m[c] = {HL{RV}};
    out_m   = {CH{RV}};
    edj_m   = '0; rise_m = '0; fall_m = '0; rflag_m = '0; fflag_m = '0;
    hist1_m = {(SS+1){RV}};
    out1_m  = RV;
    edj1_m  = 1'b0; rise1_m = 1'b0; fall1_m = 1'b0; rflag1_m = 1'b0; fflag1_m = 1'b0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      hist_m[c] = {hist_m[c][HL-2:0], in_s[c]};
      edj_m[c]  = window_flips(hist_m[c], SS, MC, out_m[c]);
      rise_m[c] = edj_m[c] & ~out_m[c];
      fall_m[c] = edj_m[c] & out_m[c];
      if (edj_m[c]) out_m[c] = ~out_m[c];
    end
    rflag_m  = (rflag_m & ~clear_s) | rise_m;
    fflag_m  = (fflag_m & ~clear_s) | fall_m;
    hist1_m  = {hist1_m[SS-1:0], in1_s[0]};
    edj1_m   = window_flips(HL'(hist1_m), SS, 1, out1_m);
    rise1_m  = edj1_m & ~out1_m;
    fall1_m  = edj1_m & out1_m;
    if (edj1_m) out1_m = ~out1_m;
    rflag1_m = (rflag1_m & ~clear1_s[0]) | rise1_m;
    fflag1_m = (fflag1_m & ~clear1_s[0]) | fall1_m;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out",       32'(out_s),   32'(out_m));
    check("edj",       32'(edj_s),   32'(edj_m));
    check("rise",      32'(rise_s),  32'(rise_m));
    check("fall",      32'(fall_s),  32'(fall_m));
    check("rise_flag", 32'(rflag_s), 32'(rflag_m));
    check("fall_flag", 32'(fflag_s), 32'(fflag_m));
    check("any_edge",  32'(any_s),   32'(|edj_m));
    check("mc1_out",   32'(out1_s),  32'(out1_m));
    check("mc1_edj",   32'(edj1_s),  32'(edj1_m));
    check("mc1_rise",  32'(rise1_s), 32'(rise1_m));
    check("mc1_fall",  32'(fall1_s), 32'(fall1_m));
    check("mc1_rflag", 32'(rflag1_s), 32'(rflag1_m));
    check("mc1_fflag", 32'(fflag1_s), 32'(fflag1_m));
  endtask

  // One clock: MAX_COUNT=1 input toggles every 3 edges, model advances, then
  // outputs are sampled 1 time unit after the edge.
  task automatic tick();
    if (tcount % 3 == 0) in1_s = ~in1_s;
    model_edge();
    @(posedge clock);
    #1;
    tcount++;
    check_all();
  endtask

  initial begin
    logic [3:0] d1;
    int         lat;
    logic       seen;

    // Reset state
    reset_n  = 1'b0;
    in_s     = '0;
    clear_s  = '0;
    in1_s    = 1'b0;
    clear1_s = 1'b0;
    d1       = 4'b0000;
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;

    // Idle 40 cycles; the MAX_COUNT=1 channel must track its input 3 edges later
    for (int n = 1; n <= 40; n++) begin
      tick();
      d1 = {d1[2:0], in1_s[0]};
      if (n >= 4) begin
        check("mc1_delay", 32'(out1_s), 32'(d1[2]));
        check("mc1_pulse", 32'(edj1_s), 32'(d1[2] ^ d1[3]));
      end
    end
    check("idle_out",   32'(out_s),            32'h0);
    check("idle_flags", 32'({rflag_s, fflag_s}), 32'h0);

    // Rising edge on channel 0: accepted 18 edges after first sample
    in_s[0] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (lat == 0 && out_s[0] === 1'b1) begin
        lat = n;
        check("rise0_pulse", 32'({rise_s[0], edj_s[0], any_s}), 32'h7);
      end
    end
    check("rise0_latency", 32'(lat), 32'd18);
    check("rise0_flag",    32'(rflag_s[0]), 32'h1);

    // Channel 1: 1-cycle glitch every 10 cycles never gets accepted
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      in_s[1] = (n % 10 == 9) ? 1'b1 : 1'b0;
      tick();
      seen = seen | edj_s[1];
    end
    in_s[1] = 1'b0;
    check("glitch_out",   32'(out_s[1]), 32'h0);
    check("glitch_pulse", 32'(seen),     32'h0);

    // Channel 2: high, then low with clear coinciding with the fall pulse
    in_s[2] = 1'b1;
    for (int n = 0; n < 20; n++) tick();
    in_s[2] = 1'b0;
    for (int n = 0; n < 17; n++) tick();
    clear_s[2] = 1'b1;
    tick();
    check("fall2_pulse", 32'(fall_s[2]),  32'h1);
    check("fall2_flag",  32'(fflag_s[2]), 32'h1);
    clear_s[2] = 1'b0;
    tick();
    clear_s[2] = 1'b1;
    tick();
    check("fall2_cleared", 32'(fflag_s[2]), 32'h0);
    clear_s[2] = 1'b0;

    // Channel 3: reset mid-count (counter at 9), then the count restarts
    in_s[3] = 1'b1;
    for (int n = 0; n < 11; n++) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_out_zero", 32'(out_s), 32'h0);
    #2;
    reset_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (lat == 0 && out_s[3] === 1'b1) lat = n;
    end
    check("rst_restart_latency", 32'(lat), 32'd18);

    // Randomised phase: slow random toggles and random clears
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(29, 0) == 0) in_s[c] = ~in_s[c];
        clear_s[c] = ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0;
      end
      clear1_s[0] = ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
